sweep_ctrl: RTL and testbench



---
 rtl/sweep_ctrl_pkg.sv | 19 +
 rtl/sweep_ctrl_counter.sv | 23 ++
 rtl/sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the triangle-sweep controller and its counter datapath.
package sweep_ctrl_pkg;

  localparam int W  = 8;
  localparam int CW = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_SEEK  = 3'd2;
  localparam state_t ST_UP    = 3'd3;
  localparam state_t ST_DOWN  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/sweep_ctrl_counter.sv
// Up/down wrap-around counter datapath; reset has priority over enable.
module counter
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      if (direction == DIR_UP) count <= count + 1'b1;
      else                     count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Sequences the counter through clear, seek-to-lo and repeated lo->hi->lo ramps.
//
// state | meaning
// IDLE  | waiting for start; counter holds
// CLEAR | counter reset for one cycle
// SEEK  | counting up from 0 to lo
// UP    | ramping lo -> hi
// DOWN  | ramping hi -> lo, sweep counted on reaching lo
// DONE  | one-cycle done pulse, counter holds lo
module sweep_ctrl
  import sweep_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [CW-1:0] cycles,
  output logic [W-1:0]  count,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state, state_nxt;
  logic [CW-1:0] sweep, sweep_nxt, sweep_inc;
  logic [W-1:0]  lo_r, hi_r;
  logic [CW-1:0] cyc_r;
  logic          err_r;
  logic          cnt_en, cnt_dir, clear, accept, reject;

  assign sweep_inc = sweep + 1'b1;

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    cnt_en    = 1'b0;
    cnt_dir   = DIR_DOWN;
    clear     = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    done      = 1'b0;
    // abort beats pause; pause only freezes the states where the counter moves
    if (state != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
    end else if (pause && state != ST_IDLE && state != ST_DONE) begin
      state_nxt = state;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (lo < hi) begin
              accept    = 1'b1;
              sweep_nxt = '0;
              state_nxt = ST_CLEAR;
            end else begin
              reject = 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          clear     = 1'b1;
          state_nxt = ST_SEEK;
        end
        ST_SEEK: begin
          cnt_en  = 1'b1;
          cnt_dir = DIR_UP;
          if (count == lo_r) state_nxt = ST_UP;
        end
        ST_UP: begin
          cnt_en = 1'b1;
          if (count == hi_r) begin
            cnt_dir   = DIR_DOWN;
            state_nxt = ST_DOWN;
          end else begin
            cnt_dir = DIR_UP;
          end
        end
        ST_DOWN: begin
          if (count == lo_r) begin
            sweep_nxt = sweep_inc;
            // cycles == 0 never matches, so the sweep counter just wraps
            if (cyc_r != '0 && sweep_inc == cyc_r) begin
              state_nxt = ST_DONE;
            end else begin
              cnt_en    = 1'b1;
              cnt_dir   = DIR_UP;
              state_nxt = ST_UP;
            end
          end else begin
            cnt_en  = 1'b1;
            cnt_dir = DIR_DOWN;
          end
        end
        ST_DONE: begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sweep <= '0;
      err_r <= 1'b0;
      lo_r  <= '0;
      hi_r  <= '0;
      cyc_r <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
      err_r <= reject;
      if (accept) begin
        lo_r  <= lo;
        hi_r  <= hi;
        cyc_r <= cycles;
      end
    end
  end

  counter #(.WIDTH(W)) u_counter (
    .clk       (clk),
    .rst       (rst | clear),
    .enable    (cnt_en),
    .direction (cnt_dir),
    .count     (count)
  );

  assign dir  = cnt_en & cnt_dir;
  assign busy = (state != ST_IDLE);
  assign err  = err_r;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: expected count trajectories built from the sweep rules.
module tb_sweep_ctrl;

  logic       clk, rst, start, abort, pause;
  logic [7:0] lo, hi;
  logic [3:0] cycles;
  logic [7:0] count;
  logic       dir, busy, done, err;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mcount;

  sweep_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .pause  (pause),
    .lo     (lo),
    .hi     (hi),
    .cycles (cycles),
    .count  (count),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    lo = 8'd0; hi = 8'd0; cycles = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", dir); end
    rst = 1'b0;
    mcount = 8'd0;
  endtask

  // Runs one finite sweep and checks count/busy/done/dir/err every cycle.
  // len returns the number of edges from the accepting edge until IDLE.
  task automatic run_sweep(input string name, input logic [7:0] l, input logic [7:0] h,
                           input logic [3:0] c, input int pause_pct, input int pause_at,
                           input int pause_len, input bit rand_start, output int len);
    logic [7:0] t[$];
    int n, p, guard, pause_left;
    bit pz, paused_once, exp_dir;
    t.push_back(8'd0);
    for (int v = 1; v <= int'(l); v++) t.push_back(8'(v));
    for (int s = 0; s < int'(c); s++) begin
      for (int v = int'(l) + 1; v <= int'(h); v++) t.push_back(8'(v));
      for (int v = int'(h) - 1; v >= int'(l); v--) t.push_back(8'(v));
    end
    t.push_back(l);
    n = t.size();
    lo = l; hi = h; cycles = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    len = 0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_accept_busy: got %b want 1", name, busy); end
    n_cmp++; if (count !== mcount) begin n_bad++; $display("FAIL %s_accept_count: got %0d want %0d", name, count, mcount); end
    p = 0; guard = 0; paused_once = 0; pause_left = 0;
    while (p <= n && guard < 4000) begin
      guard++;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1 (step %0d)", name, busy, p); end
      n_cmp++; if (done !== (p == n)) begin n_bad++; $display("FAIL %s_done: got %b want %b (step %0d)", name, done, p == n, p); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s_err: got %b want 0 (step %0d)", name, err, p); end
      pz = 1'b0;
      if (pause_left > 0) begin
        pz = 1'b1; pause_left--;
      end else if (pause_at >= 0 && !paused_once && p > 0 && p < n && int'(mcount) == pause_at && t[p] > mcount) begin
        paused_once = 1'b1; pz = 1'b1; pause_left = pause_len - 1;
      end else if (pause_pct > 0 && int'($urandom % 100) < pause_pct) begin
        pz = 1'b1;
      end
      pause = pz;
      if (rand_start) begin
        start = ($urandom % 4 == 0);
        lo = 8'($urandom); hi = 8'($urandom); cycles = 4'($urandom);
      end
      #1;
      exp_dir = (p > 0 && p < n && !pz && t[p] > mcount);
      n_cmp++; if (dir !== exp_dir) begin n_bad++; $display("FAIL %s_dir: got %b want %b (step %0d)", name, dir, exp_dir, p); end
      @(posedge clk); #1;
      len++;
      if (p == n) p = n + 1;
      else if (!pz) begin mcount = t[p]; p++; end
      n_cmp++; if (count !== mcount) begin n_bad++; $display("FAIL %s_count: got %0d want %0d (step %0d)", name, count, mcount, p); end
    end
    start = 1'b0; pause = 1'b0;
    if (guard >= 4000) begin n_cmp++; n_bad++; $display("FAIL %s_timeout: got running want idle", name); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_end_busy: got %b want 0", name, busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_end_done: got %b want 0", name, done); end
  endtask

  task automatic test_basic();
    int len;
    run_sweep("basic", 8'd2, 8'd4, 4'd1, 0, -1, 0, 1'b0, len);
    n_cmp++; if (len != 9) begin n_bad++; $display("FAIL basic_len: got %0d want 9", len); end
  endtask

  task automatic test_err_case(input string name, input logic [7:0] l, input logic [7:0] h);
    lo = l; hi = h; cycles = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL %s_err: got %b want 1", name, err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", name, busy); end
    n_cmp++; if (count !== mcount) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", name, count, mcount); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s_err_clear: got %b want 0", name, err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy2: got %b want 0", name, busy); end
  endtask

  task automatic test_err();
    test_err_case("err_eq", 8'd5, 8'd5);
    test_err_case("err_inv", 8'd7, 8'd3);
  endtask

  task automatic test_two_cycles();
    int len;
    run_sweep("two_cyc", 8'd0, 8'd3, 4'd2, 0, -1, 0, 1'b0, len);
    n_cmp++; if (mcount !== 8'd0) begin n_bad++; $display("FAIL two_cyc_final: got %0d want 0", mcount); end
  endtask

  task automatic test_pause();
    int len0, len1;
    run_sweep("nopause", 8'd1, 8'd6, 4'd1, 0, -1, 0, 1'b0, len0);
    run_sweep("pause", 8'd1, 8'd6, 4'd1, 0, 4, 3, 1'b0, len1);
    n_cmp++; if (len1 != len0 + 3) begin n_bad++; $display("FAIL pause_len: got %0d want %0d", len1, len0 + 3); end
  endtask

  task automatic test_infinite();
    logic [7:0] q[$];
    int idx;
    bit hit;
    for (int v = 0; v <= 250; v++) q.push_back(8'(v));
    for (int s = 0; s < 19; s++) begin
      for (int v = 251; v <= 255; v++) q.push_back(8'(v));
      for (int v = 254; v >= 250; v--) q.push_back(8'(v));
    end
    lo = 8'd250; hi = 8'd255; cycles = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // one extra idle-looking edge: the CLEAR state is entered on the accepting edge
    @(posedge clk); #1;
    idx = 0; hit = 1'b0;
    while (idx < q.size() - 1) begin
      n_cmp++; if (count !== q[idx]) begin n_bad++; $display("FAIL inf_count: got %0d want %0d (idx %0d)", count, q[idx], idx); end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL inf_status: got done=%b busy=%b want done=0 busy=1", done, busy); end
      if (idx > 250 + 17 * 10 && q[idx] == 8'd253) begin hit = 1'b1; break; end
      @(posedge clk); #1;
      idx++;
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL inf_reach: got no abort point want count 253"); end
    abort = 1'b1; pause = 1'b1;
    #1;
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL inf_abort_dir: got %b want 0", dir); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL inf_abort_done: got %b want 0", done); end
    @(posedge clk); #1;
    abort = 1'b0; pause = 1'b0;
    n_cmp++; if (count !== 8'd253) begin n_bad++; $display("FAIL inf_abort_count: got %0d want 253", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL inf_abort_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL inf_abort_done2: got %b want 0", done); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 8'd253) begin n_bad++; $display("FAIL inf_idle_hold: got %0d want 253", count); end
    mcount = 8'd253;
  endtask

  task automatic test_rst_mid();
    int guard;
    bit seen_top;
    lo = 8'd0; hi = 8'd10; cycles = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    lo = 8'd5; hi = 8'd3; cycles = 4'd2;
    guard = 0; seen_top = 1'b0;
    while (guard < 40) begin
      guard++;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy_start_err: got %b want 0", err); end
      if (count == 8'd10) seen_top = 1'b1;
      if (seen_top && count == 8'd9) break;
      @(posedge clk); #1;
    end
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL rst_mid_reach: got %0d want 9", count); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy_after: got %b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_idle: got busy=%b count=%0d want busy=0 count=0", busy, count); end
    mcount = 8'd0;
  endtask

  task automatic test_random();
    int len;
    logic [7:0] l, h;
    logic [3:0] c;
    for (int k = 0; k < 6; k++) begin
      l = 8'($urandom_range(30, 0));
      h = l + 8'($urandom_range(8, 1));
      c = 4'($urandom_range(3, 1));
      run_sweep("rand", l, h, c, 25, -1, 0, 1'b1, len);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_two_cycles();
    test_pause();
    test_infinite();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
